pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Parametrised, elastic successor to the fixed IF/ID register: a generic inter-stage pipeline register carrying an arbitrary-width payload with a valid/ready handshake, an optional 2-entry skid buffer, and synchronous flush with NOP-fill.
- Instantiated between every stage pair (IF/ID, ID/EX, EX/MEM, MEM/WB) of the AK-16b pipeline.
- Replaces ad-hoc stall wiring: upstream stalls by observing in_ready, downstream stalls by deasserting out_ready.

Parameters:
- DATA_W, 32, payload width in bits (IF/ID instance packs pc[15:0] and instr[15:0]).
- NOP_VAL, 0, payload value driven on out_data whenever out_valid=0, and loaded on flush/reset.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous kill of all held entries (branch/jump redirect).
- in_valid  input  1  upstream payload valid.
- in_ready  output  1  stage can accept; a transfer occurs when in_valid & in_ready.
- in_data  input  DATA_W  upstream payload.
- out_valid  output  1  out_data is a live instruction.
- out_ready  input  1  downstream accepts; a transfer occurs when out_valid & out_ready.
- out_data  output  DATA_W  payload to next stage.
- occupancy  output  2  number of held entries (0..2; max 1 when SKID=0).

Behaviour:
- Storage: main entry (drives out_*) plus skid entry (SKID=1 only), each with its own valid bit.
- Reset (async) and flush (sync) have the same effect: main_valid=0, skid_valid=0, out_data=NOP_VAL, occupancy=0, out_valid=0.
  - SKID=1: in_ready=1 after reset or flush.
  - Flush overrides every same-cycle transfer; a payload offered in the flush cycle is dropped, even if in_ready=1.
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N. Throughput is 1 per cycle when out_ready is held high.
- Ordering is strict FIFO: no payload is duplicated or lost except by flush.
- out_data equals NOP_VAL whenever out_valid=0. Decode treats NOP_VAL as ADD R0,R0,R0.
- SKID=1 states (encoded by occupancy); in_ready = !skid_valid, registered, with no combinational path from out_ready.
  - EMPTY:
    - in fire -> ONE, main<=in_data.
  - ONE:
    - in fire and out fire -> ONE, main<=in_data.
    - in fire only -> FULL, skid<=in_data.
    - out fire only -> EMPTY, main<=NOP_VAL.
    - neither -> hold.
  - FULL (in_ready=0):
    - out fire -> ONE, main<=skid, skid cleared to NOP_VAL.
    - otherwise hold.
- SKID=0: in_ready = !main_valid | out_ready (combinational). Transitions are as for EMPTY/ONE above; the FULL state is unreachable.
- in_data is ignored when in_valid=0. out_ready is ignored when out_valid=0.
- Reset deasserted mid-stream: the first accepted payload after release behaves as from EMPTY.
- Asserting rst at any time clears all entries asynchronously; no partial state survives.

Decomposition:
- Shared package ak16_pipe_pkg:
  - NOP_INSTR constant (16'h0000).
  - Occupancy encodings OCC_EMPTY=0, OCC_ONE=1, OCC_FULL=2.
  - Per-stage payload widths (IF_ID_W=32, etc.).
- No sub-module: a single module with a generate branch on SKID.

Test Plan:
- Reset: assert rst mid-cycle with 2 entries held -> immediately out_valid=0, out_data=NOP_VAL, occupancy=0, in_ready=1.
- Streaming: out_ready=1; feed in_data 0x0010_1234, 0x0012_5678, 0x0014_9ABC on consecutive cycles -> each appears one cycle later in order, in_ready stays 1, occupancy=1 throughout.
- Backpressure (SKID=1): out_ready=0 while feeding A, B, C -> occupancy goes 1 then 2, in_ready=0 after B, C held off upstream. Raise out_ready -> A, B, C emerge in order, none lost or duplicated.
- Flush while FULL: occupancy=2, flush=1 with in_valid=1 carrying D -> next cycle occupancy=0, out_data=NOP_VAL, and D never appears at the output.
- Simultaneous fire in ONE: in fire and out fire in the same cycle -> occupancy stays 1, out_data updates to the new payload.
- SKID=0 build: out_ready=0 with main held -> in_ready=0. Set out_ready=1 -> in_ready=1 combinationally in the same cycle, and a pass-through occurs at 1 payload/cycle.

Source files
------------

// File: rtl/ak16_pipe_pkg.sv
// ---------------------------------------------------------------------------
// ak16_pipe_pkg
// Shared definitions for the AK-16b inter-stage pipeline registers:
//   NOP_INSTR      - instruction encoding decode treats as ADD R0,R0,R0
//   occ_e          - encoding of the occupancy output (0, 1 or 2 held entries)
//   *_W            - payload widths of the four stage-pair instances
//   occ_encode()   - maps the main/skid valid bits onto occ_e
// ---------------------------------------------------------------------------
package ak16_pipe_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // IF/ID carries {pc[15:0], instr[15:0]}; later stages add decoded fields.
  localparam int IF_ID_W  = 32;
  localparam int ID_EX_W  = 64;
  localparam int EX_MEM_W = 48;
  localparam int MEM_WB_W = 40;

  // The skid entry is only ever valid while the main entry is, so the two
  // bits collapse to three occupancy levels.
  function automatic occ_e occ_encode(input logic main_v, input logic skid_v);
    if (!main_v)     return OCC_EMPTY;
    else if (skid_v) return OCC_FULL;
    else             return OCC_ONE;
  endfunction

endpackage

// File: rtl/pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// pipe_stage_elastic
// Generic elastic pipeline register with valid/ready handshake on both sides,
// optional two-entry skid buffer and synchronous flush with NOP fill.
//
// Parameters:
//   DATA_W   payload width
//   NOP_VAL  value shown on out_data while out_valid=0, loaded on flush/reset
//   SKID     1: main + skid entry, in_ready registered (= !skid_valid)
//            0: main entry only, in_ready = !main_valid | out_ready
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   flush            synchronous kill of every held entry, overrides transfers
//   in_valid/in_ready/in_data     upstream handshake and payload
//   out_valid/out_ready/out_data  downstream handshake and payload
//   occupancy        number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_elastic
  import ak16_pipe_pkg::*;
#(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter bit                SKID    = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  generate
    if (SKID) begin : g_skid
      logic              main_valid;
      logic              skid_valid;
      logic [DATA_W-1:0] main_data;
      logic [DATA_W-1:0] skid_data;
      logic              in_fire;

      // in_ready comes straight from a flop, so upstream never sees a
      // combinational path from out_ready.
      assign in_ready  = !skid_valid;
      assign in_fire   = in_valid & !skid_valid;
      assign out_valid = main_valid;
      assign out_data  = main_data;
      assign occupancy = occ_encode(main_valid, skid_valid);

      // Payload registers are reloaded with NOP_VAL whenever an entry empties
      // so that out_data needs no output mux.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_data  <= NOP_VAL;
          skid_data  <= NOP_VAL;
        end else if (flush) begin
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
          main_data  <= NOP_VAL;
          skid_data  <= NOP_VAL;
        end else if (!main_valid) begin
          if (in_fire) begin
            main_valid <= 1'b1;
            main_data  <= in_data;
          end
        end else if (!skid_valid) begin
          if (in_fire && out_ready) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_data  <= in_data;
          end else if (out_ready) begin
            main_valid <= 1'b0;
            main_data  <= NOP_VAL;
          end
        end else if (out_ready) begin
          // Full: the older skid payload moves up into the main entry.
          main_data  <= skid_data;
          skid_valid <= 1'b0;
          skid_data  <= NOP_VAL;
        end
      end
    end else begin : g_single
      logic              main_valid;
      logic [DATA_W-1:0] main_data;
      logic              in_fire;
      logic              out_fire;

      // Accepting while occupied is only legal when the current entry
      // leaves in the same cycle, hence the combinational out_ready term.
      assign in_ready  = !main_valid | out_ready;
      assign in_fire   = in_valid & in_ready;
      assign out_fire  = main_valid & out_ready;
      assign out_valid = main_valid;
      assign out_data  = main_data;
      assign occupancy = occ_encode(main_valid, 1'b0);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          main_valid <= 1'b0;
          main_data  <= NOP_VAL;
        end else if (flush) begin
          main_valid <= 1'b0;
          main_data  <= NOP_VAL;
        end else if (in_fire) begin
          main_valid <= 1'b1;
          main_data  <= in_data;
        end else if (out_fire) begin
          main_valid <= 1'b0;
          main_data  <= NOP_VAL;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_elastic
// Self-checking bench for pipe_stage_elastic. One instance is built with the
// skid buffer (dut) and one without (dut0); both share clk, rst and flush.
// Directed vectors and hand sequences cover the listed corner cases, then a
// randomized run compares both instances with queue-based reference models.
// ---------------------------------------------------------------------------
module tb_pipe_stage_elastic;

  localparam int          W   = 32;
  localparam logic [W-1:0] NOP = 32'hA5A5_0000;

  logic         clk;
  logic         rst;
  logic         flush;

  logic         in_valid,  in_ready,  out_valid,  out_ready;
  logic [W-1:0] in_data,   out_data;
  logic [1:0]   occupancy;

  logic         in_valid0, in_ready0, out_valid0, out_ready0;
  logic [W-1:0] in_data0,  out_data0;
  logic [1:0]   occupancy0;

  int checks_total;
  int checks_passed;

  pipe_stage_elastic #(.DATA_W(W), .NOP_VAL(NOP), .SKID(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_elastic #(.DATA_W(W), .NOP_VAL(NOP), .SKID(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .occupancy(occupancy0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One directed vector: inputs for a cycle and the SKID=1 outputs expected
  // just after the following rising edge.
  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         ordy;
    logic         fl;
    logic         e_ov;
    logic [W-1:0] e_od;
    logic [1:0]   e_occ;
    logic         e_ir;
  } vec_t;

  vec_t vecs[18];

  // Reference contents of each instance, oldest entry at index 0.
  logic [W-1:0] q1[$];
  logic [W-1:0] q0[$];

  task automatic checkOutput(input string name, input logic [W-1:0] act,
                             input logic [W-1:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic applyStimulus(input logic iv, input logic [W-1:0] id,
                               input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic checkSkid(input string tag, input logic ov, input logic [W-1:0] od,
                           input logic [1:0] occ, input logic ir);
    checkOutput({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    checkOutput({tag, " out_data"},  out_data, od);
    checkOutput({tag, " occupancy"}, {30'd0, occupancy}, {30'd0, occ});
    checkOutput({tag, " in_ready"},  {31'd0, in_ready}, {31'd0, ir});
  endtask

  task automatic checkSingle(input string tag, input logic ov, input logic [W-1:0] od,
                             input logic [1:0] occ, input logic ir);
    checkOutput({tag, " out_valid0"}, {31'd0, out_valid0}, {31'd0, ov});
    checkOutput({tag, " out_data0"},  out_data0, od);
    checkOutput({tag, " occupancy0"}, {30'd0, occupancy0}, {30'd0, occ});
    checkOutput({tag, " in_ready0"},  {31'd0, in_ready0}, {31'd0, ir});
  endtask

  // Randomized cycle: drive, compare against the queue models at negedge,
  // then advance the models with whatever transferred at the rising edge.
  task automatic randomCycle(input int n);
    logic         fl;
    logic         ir1, ir0;
    logic [1:0]   occ1, occ0;
    fl = ($urandom_range(0, 19) == 0);
    applyStimulus($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, fl);
    in_valid0  = $urandom_range(0, 3) != 0;
    in_data0   = $urandom;
    out_ready0 = $urandom_range(0, 2) != 0;
    @(negedge clk);
    ir1  = (q1.size() < 2);
    ir0  = (q0.size() == 0) || out_ready0;
    occ1 = 2'(q1.size());
    occ0 = 2'(q0.size());
    checkSkid($sformatf("rnd%0d", n), q1.size() > 0,
              (q1.size() > 0) ? q1[0] : NOP, occ1, ir1);
    checkSingle($sformatf("rnd%0d", n), q0.size() > 0,
                (q0.size() > 0) ? q0[0] : NOP, occ0, ir0);
    @(posedge clk);
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && out_ready) void'(q1.pop_front());
      if (in_valid && ir1) q1.push_back(in_data);
      if (q0.size() > 0 && out_ready0) void'(q0.pop_front());
      if (in_valid0 && ir0) q0.push_back(in_data0);
    end
    #1;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    rst = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    in_valid0 = 1'b0; in_data0 = '0; out_ready0 = 1'b0;

    // Streaming
    vecs[0]  = '{1'b1, 32'h0010_1234, 1'b1, 1'b0, 1'b1, 32'h0010_1234, 2'd1, 1'b1};
    vecs[1]  = '{1'b1, 32'h0012_5678, 1'b1, 1'b0, 1'b1, 32'h0012_5678, 2'd1, 1'b1};
    vecs[2]  = '{1'b1, 32'h0014_9ABC, 1'b1, 1'b0, 1'b1, 32'h0014_9ABC, 2'd1, 1'b1};
    vecs[3]  = '{1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, NOP,           2'd0, 1'b1};
    // Backpressure: A, B held, C stalled until the skid drains
    vecs[4]  = '{1'b1, 32'h0000_000A, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 2'd1, 1'b1};
    vecs[5]  = '{1'b1, 32'h0000_000B, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 2'd2, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_000C, 1'b0, 1'b0, 1'b1, 32'h0000_000A, 2'd2, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 32'h0000_000B, 2'd1, 1'b1};
    vecs[8]  = '{1'b1, 32'h0000_000C, 1'b1, 1'b0, 1'b1, 32'h0000_000C, 2'd1, 1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, NOP,           2'd0, 1'b1};
    // Flush while full, with D offered in the flush cycle
    vecs[10] = '{1'b1, 32'h0000_00E1, 1'b0, 1'b0, 1'b1, 32'h0000_00E1, 2'd1, 1'b1};
    vecs[11] = '{1'b1, 32'h0000_00E2, 1'b0, 1'b0, 1'b1, 32'h0000_00E1, 2'd2, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_00DD, 1'b0, 1'b1, 1'b0, NOP,           2'd0, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_00DD, 1'b1, 1'b0, 1'b0, NOP,           2'd0, 1'b1};
    // Simultaneous in/out fire in ONE, then flush dropping an accepted offer
    vecs[14] = '{1'b1, 32'h0000_00F1, 1'b0, 1'b0, 1'b1, 32'h0000_00F1, 2'd1, 1'b1};
    vecs[15] = '{1'b1, 32'h0000_00F2, 1'b1, 1'b0, 1'b1, 32'h0000_00F2, 2'd1, 1'b1};
    vecs[16] = '{1'b1, 32'h0000_00F3, 1'b1, 1'b1, 1'b0, NOP,           2'd0, 1'b1};
    vecs[17] = '{1'b0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, NOP,           2'd0, 1'b1};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkSkid("reset", 1'b0, NOP, 2'd0, 1'b1);
    checkSingle("reset", 1'b0, NOP, 2'd0, 1'b1);

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      #1;
      checkSkid($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_od,
                vecs[i].e_occ, vecs[i].e_ir);
    end

    // Asynchronous reset with two entries held, checked before any edge.
    applyStimulus(1'b1, 32'h0000_0051, 1'b0, 1'b0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 32'h0000_0052, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkSkid("prerst", 1'b1, 32'h0000_0051, 2'd2, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    checkSkid("asyncrst", 1'b0, NOP, 2'd0, 1'b1);
    #1 rst = 1'b0;
    applyStimulus(1'b1, 32'h0000_0077, 1'b0, 1'b0);
    @(posedge clk); #1;
    checkSkid("postrst", 1'b1, 32'h0000_0077, 2'd1, 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // SKID=0: in_ready follows out_ready combinationally while occupied.
    in_valid0 = 1'b1; in_data0 = 32'h0000_0011; out_ready0 = 1'b0;
    #1 checkOutput("s0 empty in_ready0", {31'd0, in_ready0}, 32'd1);
    @(posedge clk); #1;
    in_data0 = 32'h0000_0022;
    #1 checkSingle("s0 held", 1'b1, 32'h0000_0011, 2'd1, 1'b0);
    out_ready0 = 1'b1;
    #1 checkOutput("s0 comb in_ready0", {31'd0, in_ready0}, 32'd1);
    @(posedge clk); #1;
    in_data0 = 32'h0000_0033;
    #1 checkSingle("s0 pass1", 1'b1, 32'h0000_0022, 2'd1, 1'b1);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    #1 checkSingle("s0 pass2", 1'b1, 32'h0000_0033, 2'd1, 1'b1);
    @(posedge clk); #1;
    checkSingle("s0 drained", 1'b0, NOP, 2'd0, 1'b1);

    // Randomized comparison against the queue models from a clean reset.
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    out_ready0 = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q1.delete();
    q0.delete();
    for (int n = 0; n < 500; n++) randomCycle(n);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
